zero_pad_ctrl: RTL

//  Sequencer for the zero_pad datapath stage. It collects one SIZExSIZE feature tile from a

---
 rtl/zero_pad_ctrl_if.sv | 29 ++
 rtl/zero_pad_ctrl.sv | 112 +++++++++++
 2 files changed

// File: rtl/zero_pad_ctrl_if.sv
// Element-stream bundle for zero_pad_ctrl: upstream tile elements in, padded elements out.
// slave is the controller side; master is the source/sink environment.
interface zero_pad_ctrl_if #(
    parameter int unsigned SIZE   = 5,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned N  = 2 * SIZE - 1;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [IW-1:0]     out_row;
    logic [IW-1:0]     out_col;
    logic              out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_row, out_col, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_row, out_col, out_last
    );
endinterface

// File: rtl/zero_pad_ctrl.sv
// Sequencer around zero_pad: loads a SIZExSIZE tile, pulses pad_en once, then streams the
// registered NxN padded tile back out in raster order.
module zero_pad_ctrl #(
    parameter int unsigned SIZE   = 5,
    parameter int unsigned DATA_W = 32,
    localparam int unsigned N     = 2 * SIZE - 1
) (
    input  logic                                clk,
    input  logic                                reset,
    zero_pad_ctrl_if.slave                      bus,
    output logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0] pad_tile,
    output logic                                pad_en,
    output logic                                pad_rst,
    input  logic [N-1:0][N-1:0][DATA_W-1:0]     pad_data,
    output logic                                busy
);
    localparam int unsigned LW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {StLoad, StPad, StStream} state_e;

    state_e                               state_q;
    logic [LW-1:0]                        ld_row_q, ld_col_q;
    logic [IW-1:0]                        out_row_q, out_col_q;
    logic                                 in_ready_q, pad_en_q, out_valid_q, out_last_q, busy_q;
    logic [SIZE-1:0][SIZE-1:0][DATA_W-1:0] tile_q;

    logic in_fire, out_fire, ld_col_end, ld_last, out_col_end;

    assign in_fire     = bus.in_valid & in_ready_q;
    assign out_fire    = out_valid_q & bus.out_ready;
    assign ld_col_end  = (ld_col_q == LW'(SIZE - 1));
    assign ld_last     = ld_col_end && (ld_row_q == LW'(SIZE - 1));
    assign out_col_end = (out_col_q == IW'(N - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StLoad;
            ld_row_q    <= '0;
            ld_col_q    <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            tile_q      <= '0;
            in_ready_q  <= 1'b1;
            pad_en_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StLoad: begin
                    if (in_fire) begin
                        tile_q[ld_row_q][ld_col_q] <= bus.in_data;
                        if (ld_col_end) begin
                            ld_col_q <= '0;
                            if (ld_last) begin
                                ld_row_q   <= '0;
                                state_q    <= StPad;
                                in_ready_q <= 1'b0;
                                pad_en_q   <= 1'b1;
                                busy_q     <= 1'b1;
                            end else begin
                                ld_row_q <= ld_row_q + LW'(1);
                            end
                        end else begin
                            ld_col_q <= ld_col_q + LW'(1);
                        end
                    end
                end
                StPad: begin
                    // zero_pad captures on this edge, so its output is valid from next cycle.
                    pad_en_q    <= 1'b0;
                    out_valid_q <= 1'b1;
                    out_last_q  <= (N == 1);
                    state_q     <= StStream;
                end
                StStream: begin
                    if (out_fire) begin
                        if (out_last_q) begin
                            state_q     <= StLoad;
                            out_row_q   <= '0;
                            out_col_q   <= '0;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            busy_q      <= 1'b0;
                            in_ready_q  <= 1'b1;
                        end else if (out_col_end) begin
                            out_col_q <= '0;
                            out_row_q <= out_row_q + IW'(1);
                        end else begin
                            out_col_q  <= out_col_q + IW'(1);
                            out_last_q <= (out_row_q == IW'(N - 1)) &&
                                          ((out_col_q + IW'(1)) == IW'(N - 1));
                        end
                    end
                end
                default: state_q <= StLoad;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_row   = out_row_q;
    assign bus.out_col   = out_col_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_data  = pad_data[out_row_q][out_col_q];
    assign pad_tile      = tile_q;
    assign pad_en        = pad_en_q;
    assign pad_rst       = reset;
    assign busy          = busy_q;
endmodule
